// File: rtl/regfile_writeback_scheduler.sv
// regfile_writeback_scheduler
// Round-robin arbiter that shares the single write port of `registers`
// between N_REQ writeback requesters, plus a 32-entry pending-write
// scoreboard that decode uses to stall on RAW and WAW hazards.
// Optional feature macro: WB_FORWARD_EN. It adds bypass outputs from the
// commit stage and removes the RAW stall for a source being written this
// cycle.
module regfile_writeback_scheduler #(
    parameter int N_REQ  = 2,
    parameter int TAG_W  = 5,
    parameter int WORD_W = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      issue_valid,
    input  logic [TAG_W-1:0]          issue_rd,
    input  logic                      issue_writes_rd,
    input  logic [TAG_W-1:0]          issue_rs1,
    input  logic [TAG_W-1:0]          issue_rs2,
    input  logic                      issue_uses_rs1,
    input  logic                      issue_uses_rs2,
    output logic                      issue_accept,
    output logic                      stall,
    input  logic [N_REQ-1:0]          wb_valid,
    input  logic [N_REQ*TAG_W-1:0]    wb_rd,
    input  logic [N_REQ*WORD_W-1:0]   wb_value,
    output logic [N_REQ-1:0]          wb_ready,
    output logic                      write_to_rd,
    output logic [TAG_W-1:0]          rd,
    output logic [WORD_W-1:0]         rd_value,
`ifdef WB_FORWARD_EN
    output logic                      fwd_rs1_valid,
    output logic [WORD_W-1:0]         fwd_rs1_value,
    output logic                      fwd_rs2_valid,
    output logic [WORD_W-1:0]         fwd_rs2_value,
`endif
    output logic [31:0]               busy
);

    localparam int PTR_W = (N_REQ > 2) ? 2 : 1;

    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              write_to_rd_q;
    logic [TAG_W-1:0]  rd_q;
    logic [WORD_W-1:0] rd_value_q;
    logic [31:0]       busy_q, busy_d;

    logic              grant_vld;
    logic [PTR_W-1:0]  grant_idx;
    logic [PTR_W:0]    cand;
    logic [PTR_W:0]    next_ptr;
    logic [TAG_W-1:0]  grant_rd;
    logic [WORD_W-1:0] grant_value;
    logic              fwd_hit_rs1;
    logic              fwd_hit_rs2;

    // Round-robin search starting at rr_ptr; the first valid requester wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        wb_ready  = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(N_REQ)) begin
                cand = cand - (PTR_W+1)'(N_REQ);
            end
            if (!grant_vld && wb_valid[cand[PTR_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[PTR_W-1:0];
            end
        end
        if (grant_vld) begin
            wb_ready[grant_idx] = 1'b1;
        end
    end

    assign grant_rd    = wb_rd[grant_idx*TAG_W +: TAG_W];
    assign grant_value = wb_value[grant_idx*WORD_W +: WORD_W];

    // Pointer moves just past the winner; it stays put on idle cycles.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        next_ptr = {1'b0, grant_idx} + 1'b1;
        if (next_ptr == (PTR_W+1)'(N_REQ)) begin
            next_ptr = '0;
        end
        if (grant_vld) begin
            rr_ptr_d = next_ptr[PTR_W-1:0];
        end
    end

`ifdef WB_FORWARD_EN
    assign fwd_hit_rs1   = write_to_rd_q && (rd_q != '0) && (rd_q == issue_rs1);
    assign fwd_hit_rs2   = write_to_rd_q && (rd_q != '0) && (rd_q == issue_rs2);
    assign fwd_rs1_valid = fwd_hit_rs1;
    assign fwd_rs2_valid = fwd_hit_rs2;
    assign fwd_rs1_value = rd_value_q;
    assign fwd_rs2_value = rd_value_q;
`else
    assign fwd_hit_rs1 = 1'b0;
    assign fwd_hit_rs2 = 1'b0;
`endif

    // Hazard check: busy[0] is never set, so x0 can never cause a stall.
    always_comb begin
        stall = issue_valid &&
                ((issue_uses_rs1 && busy_q[issue_rs1] && !fwd_hit_rs1) ||
                 (issue_uses_rs2 && busy_q[issue_rs2] && !fwd_hit_rs2) ||
                 (issue_writes_rd && busy_q[issue_rd]));
        issue_accept = issue_valid && !stall;
    end

    // Scoreboard update: clear on commit, then set on issue so set wins.
    always_comb begin
        busy_d = busy_q;
        if (write_to_rd_q) begin
            busy_d[rd_q] = 1'b0;
        end
        if (issue_accept && issue_writes_rd && (issue_rd != '0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Commit stage: the granted request drives the register file next cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr_q      <= '0;
            write_to_rd_q <= 1'b0;
            rd_q          <= '0;
            rd_value_q    <= '0;
            busy_q        <= '0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            busy_q        <= busy_d;
            write_to_rd_q <= grant_vld && (grant_rd != '0);
            if (grant_vld) begin
                rd_q       <= grant_rd;
                rd_value_q <= grant_value;
            end
        end
    end

    assign write_to_rd = write_to_rd_q;
    assign rd          = rd_q;
    assign rd_value    = rd_value_q;
    assign busy        = busy_q;

endmodule
